// File: rtl/risc16_ifetch.sv
// RISC-16 instruction fetch unit: one outstanding word read over req/ack,
// presents the fetched word on ir/ir_pc/ir_valid and honours execute-stage redirects.
module risc16_ifetch #(
   parameter int unsigned          ADDR_W   = 16,
   parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [15:0]       imem_rdata,
   output logic [15:0]       ir,
   output logic [ADDR_W-1:0] ir_pc,
   output logic              ir_valid,
   input  logic              ir_ready,
   input  logic              redirect_en,
   input  logic [ADDR_W-1:0] redirect_pc,
   input  logic              halt
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t              r_state;
   logic [ADDR_W-1:0]   r_fetch_pc;
   logic                r_squash;
   logic                r_imem_req;
   logic [ADDR_W-1:0]   r_imem_addr;
   logic [15:0]         r_ir;
   logic [ADDR_W-1:0]   r_ir_pc;
   logic                r_ir_valid;
   logic [ADDR_W-1:0]   w_next_pc;

   assign w_next_pc = r_imem_addr + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_fetch_pc  <= RESET_PC;
         r_squash    <= 1'b0;
         r_imem_req  <= 1'b0;
         r_imem_addr <= '0;
         r_ir        <= '0;
         r_ir_pc     <= '0;
         r_ir_valid  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (halt) begin
                  if (redirect_en) r_fetch_pc <= redirect_pc;
               end else begin
                  r_imem_req  <= 1'b1;
                  r_imem_addr <= redirect_en ? redirect_pc : r_fetch_pc;
                  r_state     <= REQ;
               end
            end
            REQ: begin
               if (imem_ack) begin
                  r_imem_req <= 1'b0;
                  if (r_squash || redirect_en) begin
                     r_squash <= 1'b0;
                     r_state  <= IDLE;
                     if (redirect_en) r_fetch_pc <= redirect_pc;
                  end else begin
                     r_ir       <= imem_rdata;
                     r_ir_pc    <= r_imem_addr;
                     r_ir_valid <= 1'b1;
                     r_fetch_pc <= w_next_pc;
                     r_state    <= HOLD;
                  end
               end else if (redirect_en) begin
                  // Request stays on the bus; its data is dropped when it completes.
                  r_fetch_pc <= redirect_pc;
                  r_squash   <= 1'b1;
               end
            end
            HOLD: begin
               if (redirect_en) begin
                  r_ir_valid <= 1'b0;
                  r_fetch_pc <= redirect_pc;
                  r_state    <= IDLE;
               end else if (ir_ready) begin
                  r_ir_valid <= 1'b0;
                  r_state    <= IDLE;
               end
            end
            default: begin
               r_imem_req <= 1'b0;
               r_ir_valid <= 1'b0;
               r_state    <= IDLE;
            end
         endcase
      end
   end

   assign imem_req  = r_imem_req;
   assign imem_addr = r_imem_addr;
   assign ir        = r_ir;
   assign ir_pc     = r_ir_pc;
   assign ir_valid  = r_ir_valid;

endmodule

// File: tb/tb_risc16_ifetch.sv
// Directed bench for risc16_ifetch: the bench plays instruction memory and
// keeps a scoreboard of instructions that must appear on ir.
module tb_risc16_ifetch;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_ack;
   logic [15:0] imem_rdata;
   logic [15:0] ir;
   logic [15:0] ir_pc;
   logic        ir_valid;
   logic        ir_ready;
   logic        redirect_en;
   logic [15:0] redirect_pc;
   logic        halt;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [15:0] ir;
      logic [15:0] pc;
   } exp_t;

   exp_t sb[$];

   risc16_ifetch #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid), .ir_ready(ir_ready),
      .redirect_en(redirect_en), .redirect_pc(redirect_pc), .halt(halt)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, observed=running required=finished");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, ".req"},   16'(imem_req), 16'h0000);
      chk({tag, ".addr"},  imem_addr,     16'h0000);
      chk({tag, ".ir"},    ir,            16'h0000);
      chk({tag, ".ir_pc"}, ir_pc,         16'h0000);
      chk({tag, ".valid"}, 16'(ir_valid), 16'h0000);
   endtask

   task automatic observe(input string tag);
      exp_t e;
      logic exp_v;
      exp_v = (sb.size() > 0);
      chk({tag, ".valid"}, 16'(ir_valid), 16'(exp_v));
      if (ir_valid && exp_v) begin
         e = sb.pop_front();
         chk({tag, ".ir"},    ir,    e.ir);
         chk({tag, ".ir_pc"}, ir_pc, e.pc);
      end
   endtask

   task automatic wait_req(input logic [15:0] exp_addr, input string tag);
      int n = 0;
      while (!imem_req && n < 20) begin
         tick();
         n++;
      end
      chk({tag, ".req"},  16'(imem_req), 16'h0001);
      chk({tag, ".addr"}, imem_addr,     exp_addr);
   endtask

   // Completes the outstanding request after `waits` idle cycles.
   task automatic mem_ack(input logic [15:0] data, input logic push, input int waits,
                          input logic [15:0] exp_addr, input string tag);
      for (int i = 0; i < waits; i++) begin
         chk({tag, ".wait_req"},  16'(imem_req), 16'h0001);
         chk({tag, ".wait_addr"}, imem_addr,     exp_addr);
         tick();
      end
      chk({tag, ".ack_addr"}, imem_addr, exp_addr);
      imem_rdata = data;
      imem_ack   = 1'b1;
      if (push) sb.push_back({data, exp_addr});
      tick();
      imem_ack   = 1'b0;
      imem_rdata = 16'($urandom);
      chk({tag, ".req_drop"}, 16'(imem_req), 16'h0000);
      observe(tag);
   endtask

   initial begin
      rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0; ir_ready = 1'b0;
      redirect_en = 1'b0; redirect_pc = '0; halt = 1'b0;
      tick(); tick();
      chk_reset("reset");
      rst = 1'b0;
      tick();
      wait_req(16'h0000, "t1");

      // basic fetch, consume, 3-cycle cadence
      mem_ack(16'h1C85, 1'b1, 0, 16'h0000, "t1");
      ir_ready = 1'b1;
      tick();
      ir_ready = 1'b0;
      chk("t1.consumed", 16'(ir_valid), 16'h0000);
      chk("t1.ir_keep",  ir,            16'h1C85);
      tick();
      chk("t1.next_req",  16'(imem_req), 16'h0001);
      chk("t1.next_addr", imem_addr,     16'h0001);

      // wait states, then stall in HOLD with a stray ack
      mem_ack(16'h2345, 1'b1, 3, 16'h0001, "t2");
      for (int i = 0; i < 5; i++) begin
         if (i == 2) begin
            imem_ack = 1'b1;
            imem_rdata = 16'hDEAD;
         end
         tick();
         imem_ack = 1'b0;
         chk("t2.hold_valid", 16'(ir_valid), 16'h0001);
         chk("t2.hold_ir",    ir,            16'h2345);
         chk("t2.hold_pc",    ir_pc,         16'h0001);
         chk("t2.hold_noreq", 16'(imem_req), 16'h0000);
      end
      ir_ready = 1'b1;
      tick();
      ir_ready = 1'b0;
      wait_req(16'h0002, "t2");

      // redirect coinciding with ack, then redirect before ack (squash)
      redirect_en = 1'b1; redirect_pc = 16'h0005;
      imem_ack = 1'b1; imem_rdata = 16'hBEEF;
      tick();
      redirect_en = 1'b0; imem_ack = 1'b0;
      chk("t3a.req_drop", 16'(imem_req), 16'h0000);
      observe("t3a");
      wait_req(16'h0005, "t3a");
      tick();
      redirect_en = 1'b1; redirect_pc = 16'h0040;
      tick();
      redirect_en = 1'b0;
      chk("t3b.req_kept",  16'(imem_req), 16'h0001);
      chk("t3b.addr_kept", imem_addr,     16'h0005);
      mem_ack(16'hBAD0, 1'b0, 1, 16'h0005, "t3b");
      wait_req(16'h0040, "t3b");

      // redirect in HOLD wins over ir_ready
      mem_ack(16'h4040, 1'b1, 0, 16'h0040, "t4");
      redirect_en = 1'b1; redirect_pc = 16'h0100; ir_ready = 1'b1;
      tick();
      redirect_en = 1'b0; ir_ready = 1'b0;
      chk("t4.valid_drop", 16'(ir_valid), 16'h0000);
      wait_req(16'h0100, "t4");

      // PC wrap from 0xFFFF
      mem_ack(16'h0101, 1'b1, 0, 16'h0100, "t5a");
      redirect_en = 1'b1; redirect_pc = 16'hFFFF;
      tick();
      redirect_en = 1'b0;
      chk("t5a.valid_drop", 16'(ir_valid), 16'h0000);
      wait_req(16'hFFFF, "t5b");
      mem_ack(16'hFFF0, 1'b1, 0, 16'hFFFF, "t5b");
      ir_ready = 1'b1;
      tick();
      ir_ready = 1'b0;
      wait_req(16'h0000, "t5c");

      // halt during REQ, stray ack and redirect while halted, then reset
      halt = 1'b1;
      mem_ack(16'h6066, 1'b1, 2, 16'h0000, "t6");
      ir_ready = 1'b1;
      tick();
      ir_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("t6.halt_noreq", 16'(imem_req), 16'h0000);
      end
      imem_ack = 1'b1; imem_rdata = 16'h5A5A;
      tick();
      imem_ack = 1'b0;
      chk("t6.stray_valid", 16'(ir_valid), 16'h0000);
      chk("t6.stray_req",   16'(imem_req), 16'h0000);
      redirect_en = 1'b1; redirect_pc = 16'h0777;
      tick();
      redirect_en = 1'b0;
      chk("t6.halt_redir_noreq", 16'(imem_req), 16'h0000);
      rst = 1'b1;
      tick();
      chk_reset("t6.reset");
      rst = 1'b0;
      tick(); tick();
      chk("t6.post_rst_noreq", 16'(imem_req), 16'h0000);
      halt = 1'b0;
      wait_req(16'h0000, "t6.resume");
      mem_ack(16'h7007, 1'b1, 0, 16'h0000, "t6.resume");
      halt = 1'b1; ir_ready = 1'b1;
      tick();
      ir_ready = 1'b0;
      redirect_en = 1'b1; redirect_pc = 16'h0777;
      tick();
      redirect_en = 1'b0;
      chk("t6.halt_noreq2", 16'(imem_req), 16'h0000);
      halt = 1'b0;
      wait_req(16'h0777, "t6.halt_redir");

      // reset mid-request; a late ack is ignored
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t7.rst_req_drop", 16'(imem_req), 16'h0000);
      imem_ack = 1'b1; imem_rdata = 16'hEEEE;
      tick();
      imem_ack = 1'b0;
      chk("t7.late_ack_valid", 16'(ir_valid), 16'h0000);
      chk("t7.restart_req",    16'(imem_req), 16'h0001);
      chk("t7.restart_addr",   imem_addr,     16'h0000);
      mem_ack(16'h0AAA, 1'b1, 0, 16'h0000, "t7");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/risc16_ifetch.md
Name: risc16_ifetch

Overview:
- Instruction fetch unit for the RISC-16 core.
- Issues word reads to instruction memory over a req/ack handshake and produces the 16-bit `ir` consumed by the control decoder.
- Tracks the fetch PC and accepts branch/jump redirects from the execute stage.
- One outstanding request at a time; a simple, non-pipelined fetch front end.

Parameters:
- RESET_PC, 16'h0000: first fetch address after reset.
- ADDR_W, 16: address width; word addressed, PC increments by 1.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, synchronous, active-high
- imem_req  out  1  read request to instruction memory (registered)
- imem_addr  out  ADDR_W  word address of the request; stable while imem_req=1
- imem_ack  in  1  one-cycle pulse: imem_rdata valid, request complete
- imem_rdata  in  16  instruction word returned by memory
- ir  out  16  instruction register driven to the decoder
- ir_pc  out  ADDR_W  address the current ir was fetched from
- ir_valid  out  1  ir holds a valid, unconsumed instruction
- ir_ready  in  1  decoder consumes ir this cycle when ir_valid=1
- redirect_en  in  1  one-cycle pulse: discard the current path, fetch from redirect_pc
- redirect_pc  in  ADDR_W  redirect target address
- halt  in  1  level; while 1, no new request is started

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE, fetch_pc=RESET_PC, squash=0.
  - imem_req=0, imem_addr=0, ir=16'h0000 (ADD r0,r0,r0, a NOP), ir_pc=0, ir_valid=0.
  - rst overrides every other input.
  - rst mid-request drops imem_req the next cycle; any later imem_ack is ignored while in IDLE.
- State IDLE:
  - If halt=1, remain in IDLE. A redirect arriving here still updates fetch_pc.
  - Else if redirect_en=1: imem_req<=1, imem_addr<=redirect_pc, go to REQ.
  - Else: imem_req<=1, imem_addr<=fetch_pc, go to REQ.
- State REQ (imem_req=1, imem_addr held constant):
  - ack with squash=0 and redirect_en=0: imem_req<=0, ir<=imem_rdata, ir_pc<=imem_addr, ir_valid<=1, fetch_pc<=imem_addr+1, go to HOLD.
  - ack with squash=1 or redirect_en=1: imem_req<=0, data discarded, ir_valid stays 0, squash<=0, go to IDLE.
    - If redirect_en=1 that cycle, fetch_pc<=redirect_pc.
  - No ack and redirect_en=1: fetch_pc<=redirect_pc, squash<=1. The request is NOT withdrawn; it completes and is discarded.
  - halt has no effect in REQ; the outstanding request always completes.
- State HOLD (ir_valid=1):
  - redirect_en=1 (priority over ir_ready): ir_valid<=0, fetch_pc<=redirect_pc, go to IDLE.
  - ir_ready=1: ir_valid<=0, go to IDLE.
  - Otherwise ir, ir_pc and ir_valid hold. ir retains its last value after consumption.
- Timing:
  - Zero-wait memory (ack the cycle after req rises) gives one instruction per 3 cycles: IDLE, REQ, HOLD.
  - Latency from req rising to ir_valid rising is 1 cycle after ack.
- Arithmetic: fetch_pc = imem_addr+1, modulo 2^ADDR_W; 16'hFFFF wraps to 16'h0000.
- imem_ack outside REQ is ignored.

Test Plan:
- Reset then rst=0, memory acks 1 cycle after req with word 16'h1C85 at address 0 -> imem_req=1 with addr 0x0000; ir=16'h1C85, ir_pc=0, ir_valid=1 the cycle after ack; with ir_ready=1, the next request goes to 0x0001.
- Memory with 3 wait cycles, ir_ready held 0 for 5 cycles -> imem_addr stable for the full request; ir/ir_valid held stable in HOLD; no new req until ir_ready=1.
- redirect_en with redirect_pc=0x0040 during REQ before ack at addr 0x0005 -> the ack's data is discarded with ir_valid never set; the next request goes to 0x0040.
- redirect_en to 0x0100 in HOLD with ir_ready=1 the same cycle -> ir_valid drops; the next request goes to 0x0100, not ir_pc+1.
- redirect_en to 0xFFFF, instruction fetched and consumed -> the next request goes to 0x0000 (wrap).
- halt=1 asserted during REQ, then rst=1 in a later IDLE -> the outstanding fetch completes into HOLD; after consumption no req while halt=1; rst restores all reset values and fetching resumes at RESET_PC once halt=0.
